// File: rtl/datapath_ctrl_if.sv
// Bus between the instruction issuer / datapath and datapath_ctrl.
// The slave modport is the controller's view; the master modport is the
// issuer/datapath view. Optional flag signals exist only when
// DPCTRL_FLAGS_EN is defined.
interface datapath_ctrl_if;
  // instruction handshake and fields
  logic       instr_valid;
  logic       instr_ready;
  logic       instr_li;
  logic [2:0] instr_op;
  logic [1:0] instr_rd;
  logic [1:0] instr_rs1;
  logic [1:0] instr_rs2;
  logic [3:0] instr_imm;
  logic       instr_cin;

  // datapath control
  logic [1:0] addr;
  logic       escrita;
  logic       sel21;
  logic       sel12;
  logic [3:0] dados;
  logic [2:0] operacao;
  logic       Cin;
  logic       done;

`ifdef DPCTRL_FLAGS_EN
  // datapath feedback and status flags
  logic       cout_in;
  logic [3:0] resultado_in;
  logic       flag_c;
  logic       flag_z;

  modport slave (
    input  instr_valid, instr_li, instr_op, instr_rd, instr_rs1, instr_rs2,
           instr_imm, instr_cin, cout_in, resultado_in,
    output instr_ready, addr, escrita, sel21, sel12, dados, operacao, Cin,
           done, flag_c, flag_z
  );

  modport master (
    output instr_valid, instr_li, instr_op, instr_rd, instr_rs1, instr_rs2,
           instr_imm, instr_cin, cout_in, resultado_in,
    input  instr_ready, addr, escrita, sel21, sel12, dados, operacao, Cin,
           done, flag_c, flag_z
  );
`else
  modport slave (
    input  instr_valid, instr_li, instr_op, instr_rd, instr_rs1, instr_rs2,
           instr_imm, instr_cin,
    output instr_ready, addr, escrita, sel21, sel12, dados, operacao, Cin,
           done
  );

  modport master (
    output instr_valid, instr_li, instr_op, instr_rd, instr_rs1, instr_rs2,
           instr_imm, instr_cin,
    input  instr_ready, addr, escrita, sel21, sel12, dados, operacao, Cin,
           done
  );
`endif
endinterface

// File: rtl/datapath_ctrl.sv
// datapath_ctrl: sequences a small register-file/ALU datapath.
// Load-immediate: IDLE -> WR_IMM -> DONE.
// ALU operation:  IDLE -> RD_A -> RD_B -> EXEC (1+EXEC_WAIT cycles) -> WB -> DONE.
// All outputs are registered: each transition loads the values that belong
// to the state being entered, so the outputs change together with the state.
// Optional feature macro: DPCTRL_FLAGS_EN adds carry/zero status flags that
// are captured from the datapath feedback on the WB edge.
module datapath_ctrl #(
  parameter int EXEC_WAIT = 0  // extra EXEC cycles, 0..3
) (
  input logic           clk,
  input logic           reset,  // synchronous, active low
  datapath_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    WR_IMM,
    RD_A,
    RD_B,
    EXEC,
    WB,
    DONE
  } state_t;

  localparam logic [1:0] WAIT_LOAD = 2'(EXEC_WAIT);

  state_t     state_reg;

  // instruction fields captured at the accept edge
  logic       li_reg,  li_next;
  logic [2:0] op_reg,  op_next;
  logic [1:0] rd_reg,  rd_next;
  logic [1:0] rs1_reg, rs1_next;
  logic [1:0] rs2_reg, rs2_next;
  logic [3:0] imm_reg, imm_next;
  logic       cin_reg, cin_next;

  // EXEC down-counter
  logic [1:0] wait_reg;

  // registered outputs
  logic       ready_reg;
  logic [1:0] addr_reg;
  logic       escrita_reg;
  logic       sel21_reg;
  logic       sel12_reg;
  logic [3:0] dados_reg;
  logic [2:0] operacao_reg;
  logic       cin_out_reg;
  logic       done_reg;

`ifdef DPCTRL_FLAGS_EN
  logic       flag_c_reg;
  logic       flag_z_reg;
`endif

  logic       accept;

  assign accept = (state_reg == IDLE) && ready_reg && bus.instr_valid;

  // Field capture mux: on accept the live bus fields are taken, otherwise the
  // latched copy is kept; the FSM uses the _next view so the first state of
  // an instruction already sees the new fields.
  always_comb begin
    li_next  = li_reg;
    op_next  = op_reg;
    rd_next  = rd_reg;
    rs1_next = rs1_reg;
    rs2_next = rs2_reg;
    imm_next = imm_reg;
    cin_next = cin_reg;
    if (accept) begin
      li_next  = bus.instr_li;
      op_next  = bus.instr_op;
      rd_next  = bus.instr_rd;
      rs1_next = bus.instr_rs1;
      rs2_next = bus.instr_rs2;
      imm_next = bus.instr_imm;
      cin_next = bus.instr_cin;
    end
  end

  // Controller FSM with registered outputs, field latches and optional flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= IDLE;
      li_reg       <= 1'b0;
      op_reg       <= '0;
      rd_reg       <= '0;
      rs1_reg      <= '0;
      rs2_reg      <= '0;
      imm_reg      <= '0;
      cin_reg      <= 1'b0;
      wait_reg     <= '0;
      ready_reg    <= 1'b1;
      addr_reg     <= '0;
      escrita_reg  <= 1'b0;
      sel21_reg    <= 1'b0;
      sel12_reg    <= 1'b0;
      dados_reg    <= '0;
      operacao_reg <= '0;
      cin_out_reg  <= 1'b0;
      done_reg     <= 1'b0;
`ifdef DPCTRL_FLAGS_EN
      flag_c_reg   <= 1'b0;
      flag_z_reg   <= 1'b0;
`endif
    end else begin
      li_reg       <= li_next;
      op_reg       <= op_next;
      rd_reg       <= rd_next;
      rs1_reg      <= rs1_next;
      rs2_reg      <= rs2_next;
      imm_reg      <= imm_next;
      cin_reg      <= cin_next;

      // quiet values unless the entered state drives something
      ready_reg    <= 1'b0;
      addr_reg     <= '0;
      escrita_reg  <= 1'b0;
      sel21_reg    <= 1'b0;
      sel12_reg    <= 1'b0;
      dados_reg    <= '0;
      operacao_reg <= '0;
      cin_out_reg  <= 1'b0;
      done_reg     <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (accept) begin
            if (li_next) begin
              state_reg   <= WR_IMM;
              addr_reg    <= rd_next;
              dados_reg   <= imm_next;
              escrita_reg <= 1'b1;
            end else begin
              state_reg   <= RD_A;
              addr_reg    <= rs1_next;
            end
          end else begin
            ready_reg <= 1'b1;
          end
        end

        WR_IMM: begin
          state_reg <= DONE;
          done_reg  <= 1'b1;
        end

        RD_A: begin
          state_reg <= RD_B;
          addr_reg  <= rs2_reg;
          sel12_reg <= 1'b1;
        end

        RD_B: begin
          state_reg    <= EXEC;
          addr_reg     <= rd_reg;
          sel21_reg    <= 1'b1;
          operacao_reg <= op_reg;
          cin_out_reg  <= cin_reg;
          wait_reg     <= WAIT_LOAD;
        end

        EXEC: begin
          addr_reg     <= rd_reg;
          sel21_reg    <= 1'b1;
          operacao_reg <= op_reg;
          cin_out_reg  <= cin_reg;
          if (wait_reg == 2'd0) begin
            state_reg   <= WB;
            escrita_reg <= 1'b1;
          end else begin
            wait_reg <= wait_reg - 2'd1;
          end
        end

        WB: begin
          state_reg <= DONE;
          done_reg  <= 1'b1;
`ifdef DPCTRL_FLAGS_EN
          flag_c_reg <= bus.cout_in;
          flag_z_reg <= (bus.resultado_in == 4'd0);
`endif
        end

        DONE: begin
          state_reg <= IDLE;
          ready_reg <= 1'b1;
        end

        default: begin
          state_reg <= IDLE;
          ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign bus.instr_ready = ready_reg;
  assign bus.addr        = addr_reg;
  assign bus.escrita     = escrita_reg;
  assign bus.sel21       = sel21_reg;
  assign bus.sel12       = sel12_reg;
  assign bus.dados       = dados_reg;
  assign bus.operacao    = operacao_reg;
  assign bus.Cin         = cin_out_reg;
  assign bus.done        = done_reg;
`ifdef DPCTRL_FLAGS_EN
  assign bus.flag_c      = flag_c_reg;
  assign bus.flag_z      = flag_z_reg;
`endif

endmodule

// File: tb/tb_datapath_ctrl.sv
// Testbench for datapath_ctrl: two instances (EXEC_WAIT=0 and 2) share one
// stimulus stream. A trace model expands every accepted instruction into the
// per-cycle output vectors it must produce and is compared every cycle;
// literal checks pin the model against hand-computed values.
module tb_datapath_ctrl;

  typedef struct packed {
    logic       ready;
    logic [1:0] addr;
    logic       escrita;
    logic       sel21;
    logic       sel12;
    logic [3:0] dados;
    logic [2:0] operacao;
    logic       cin;
    logic       done;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       valid;
  logic       li;
  logic [2:0] op;
  logic [1:0] rd, rs1, rs2;
  logic [3:0] imm;
  logic       cin;
`ifdef DPCTRL_FLAGS_EN
  logic       cout_in;
  logic [3:0] res;
`endif

  int checks = 0;
  int errors = 0;

  datapath_ctrl_if bus0 ();
  datapath_ctrl_if bus1 ();

  assign bus0.instr_valid = valid;
  assign bus0.instr_li    = li;
  assign bus0.instr_op    = op;
  assign bus0.instr_rd    = rd;
  assign bus0.instr_rs1   = rs1;
  assign bus0.instr_rs2   = rs2;
  assign bus0.instr_imm   = imm;
  assign bus0.instr_cin   = cin;
  assign bus1.instr_valid = valid;
  assign bus1.instr_li    = li;
  assign bus1.instr_op    = op;
  assign bus1.instr_rd    = rd;
  assign bus1.instr_rs1   = rs1;
  assign bus1.instr_rs2   = rs2;
  assign bus1.instr_imm   = imm;
  assign bus1.instr_cin   = cin;
`ifdef DPCTRL_FLAGS_EN
  assign bus0.cout_in      = cout_in;
  assign bus0.resultado_in = res;
  assign bus1.cout_in      = cout_in;
  assign bus1.resultado_in = res;
`endif

  datapath_ctrl #(.EXEC_WAIT(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  datapath_ctrl #(.EXEC_WAIT(2)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  vec_t act[2];
  assign act[0] = {bus0.instr_ready, bus0.addr, bus0.escrita, bus0.sel21, bus0.sel12,
                   bus0.dados, bus0.operacao, bus0.Cin, bus0.done};
  assign act[1] = {bus1.instr_ready, bus1.addr, bus1.escrita, bus1.sel21, bus1.sel12,
                   bus1.dados, bus1.operacao, bus1.Cin, bus1.done};
`ifdef DPCTRL_FLAGS_EN
  logic [1:0] act_f[2];
  assign act_f[0] = {bus0.flag_c, bus0.flag_z};
  assign act_f[1] = {bus1.flag_c, bus1.flag_z};
  logic [1:0] mflag[2];
`endif

  function automatic vec_t mk(input logic r, input logic [1:0] a, input logic e,
                              input logic s21, input logic s12, input logic [3:0] d,
                              input logic [2:0] o, input logic c, input logic dn);
    vec_t v;
    v.ready = r; v.addr = a; v.escrita = e; v.sel21 = s21; v.sel12 = s12;
    v.dados = d; v.operacao = o; v.cin = c; v.done = dn;
    return v;
  endfunction

  // ---------------- trace model ----------------
  // Outputs with no defined role in a state are expected at their quiet 0.
  vec_t exp_v[2];
  vec_t tr[2][8];
  int   tlen[2];
  int   tpos[2];
  bit   started = 1'b0;

  task automatic push(input int k, input vec_t v);
    tr[k][tlen[k]] = v;
    tlen[k] = tlen[k] + 1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        if (!reset) begin
          tlen[k]  = 0;
          tpos[k]  = 0;
          exp_v[k] = mk(1'b1, '0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
`ifdef DPCTRL_FLAGS_EN
          mflag[k] = 2'b00;
`endif
        end else if (started) begin
`ifdef DPCTRL_FLAGS_EN
          // the cycle just ending was the write-back cycle
          if (exp_v[k].escrita && exp_v[k].sel21)
            mflag[k] = {cout_in, (res == 4'd0)};
`endif
          if (exp_v[k].ready && valid) begin
            tlen[k] = 0;
            tpos[k] = 0;
            if (li) begin
              push(k, mk(1'b0, rd, 1'b1, 1'b0, 1'b0, imm, '0, 1'b0, 1'b0));
            end else begin
              push(k, mk(1'b0, rs1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0));
              push(k, mk(1'b0, rs2, 1'b0, 1'b0, 1'b1, '0, '0, 1'b0, 1'b0));
              for (int w = 0; w <= (k == 0 ? 0 : 2); w++)
                push(k, mk(1'b0, rd, 1'b0, 1'b1, 1'b0, '0, op, cin, 1'b0));
              push(k, mk(1'b0, rd, 1'b1, 1'b1, 1'b0, '0, op, cin, 1'b0));
            end
            push(k, mk(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1));
          end
          if (tpos[k] < tlen[k]) begin
            exp_v[k] = tr[k][tpos[k]];
            tpos[k]  = tpos[k] + 1;
          end else begin
            exp_v[k] = mk(1'b1, '0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
          end
        end
      end
      if (!reset) started = 1'b1;
    end
  end

  // ---------------- per-cycle compare ----------------
  int cyc = 0;
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (started) begin
        for (int k = 0; k < 2; k++) begin
          checks++;
          if (act[k] !== exp_v[k]) begin
            errors++;
            $display("FAIL cycle%0d dut%0d outputs: got %h expected %h", cyc, k, act[k], exp_v[k]);
          end
`ifdef DPCTRL_FLAGS_EN
          checks++;
          if (act_f[k] !== mflag[k]) begin
            errors++;
            $display("FAIL cycle%0d dut%0d flags: got %b expected %b", cyc, k, act_f[k], mflag[k]);
          end
`endif
        end
      end
    end
  end

  // ---------------- literal checks and stimulus ----------------
  task automatic chk(input string name, input logic [7:0] a, input logic [7:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, a, e);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // offer one instruction for one cycle, then scramble the fields
  task automatic offer(input logic l, input logic [2:0] o, input logic [1:0] d,
                       input logic [1:0] s1, input logic [1:0] s2,
                       input logic [3:0] im, input logic c);
    li = l; op = o; rd = d; rs1 = s1; rs2 = s2; imm = im; cin = c;
    valid = 1'b1;
    next_cycle();
    valid = 1'b0;
    li = ~li; op = ~op; rd = ~rd; rs1 = ~rs1; rs2 = ~rs2; imm = ~imm; cin = ~cin;
  endtask

  initial begin
    reset = 1'b0;
    valid = 1'b1;  // offered during reset: must not be accepted
    li = 1'b1; op = 3'd0; rd = 2'd1; rs1 = 2'd0; rs2 = 2'd0; imm = 4'hF; cin = 1'b0;
`ifdef DPCTRL_FLAGS_EN
    cout_in = 1'b0;
    res = 4'd5;
`endif
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    valid = 1'b0;
    @(negedge clk);
    chk("reset_ready", 8'(bus0.instr_ready), 8'd1);
    chk("reset_escrita", 8'(bus0.escrita), 8'd0);
    chk("reset_done", 8'(bus0.done), 8'd0);
    chk("reset_addr", 8'(bus0.addr), 8'd0);
    next_cycle();

    // load-immediate rd=2 imm=0xA
    offer(1'b1, 3'd0, 2'd2, 2'd0, 2'd0, 4'hA, 1'b0);
    @(negedge clk);
    chk("li_c1_addr", 8'(bus0.addr), 8'd2);
    chk("li_c1_sel21", 8'(bus0.sel21), 8'd0);
    chk("li_c1_dados", 8'(bus0.dados), 8'hA);
    chk("li_c1_escrita", 8'(bus0.escrita), 8'd1);
    @(negedge clk);
    chk("li_c2_done", 8'(bus0.done), 8'd1);
    repeat (8) next_cycle();

    // ALU op=3 rs1=0 rs2=1 rd=3 cin=1
`ifdef DPCTRL_FLAGS_EN
    cout_in = 1'b1;
    res = 4'd0;
`endif
    offer(1'b0, 3'd3, 2'd3, 2'd0, 2'd1, 4'h0, 1'b1);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      case (c)
        1: begin chk("alu_c1_addr", 8'(bus0.addr), 8'd0); chk("alu_c1_sel12", 8'(bus0.sel12), 8'd0); end
        2: begin chk("alu_c2_addr", 8'(bus0.addr), 8'd1); chk("alu_c2_sel12", 8'(bus0.sel12), 8'd1); end
        3: begin chk("alu_c3_addr", 8'(bus0.addr), 8'd3); chk("alu_c3_escrita", 8'(bus0.escrita), 8'd0);
                 chk("alu_c3_op", 8'(bus0.operacao), 8'd3); end
        4: begin chk("alu_c4_addr", 8'(bus0.addr), 8'd3); chk("alu_c4_escrita", 8'(bus0.escrita), 8'd1);
                 chk("alu_c4_cin", 8'(bus0.Cin), 8'd1); chk("wait2_c4_escrita", 8'(bus1.escrita), 8'd0); end
        5: begin chk("alu_c5_done", 8'(bus0.done), 8'd1); chk("wait2_c5_done", 8'(bus1.done), 8'd0); end
        6: chk("wait2_c6_escrita", 8'(bus1.escrita), 8'd1);
        default: chk("wait2_c7_done", 8'(bus1.done), 8'd1);
      endcase
      next_cycle();
    end
`ifdef DPCTRL_FLAGS_EN
    @(negedge clk);
    chk("flags_after_alu_dut0", 8'(act_f[0]), 8'b11);
    chk("flags_after_alu_dut1", 8'(act_f[1]), 8'b11);
    next_cycle();
    cout_in = 1'b0;
    res = 4'd7;
    offer(1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 4'h9, 1'b0);
    repeat (6) next_cycle();
    @(negedge clk);
    chk("flags_after_li_dut0", 8'(act_f[0]), 8'b11);
    chk("flags_after_li_dut1", 8'(act_f[1]), 8'b11);
    next_cycle();
    res = 4'd3;
`endif
    repeat (2) next_cycle();

    // further ALU patterns, including rd equal to a source
    offer(1'b0, 3'd5, 2'd1, 2'd1, 2'd2, 4'h0, 1'b0);
    repeat (10) next_cycle();
    offer(1'b0, 3'd7, 2'd0, 2'd3, 2'd0, 4'h0, 1'b1);
    repeat (10) next_cycle();

    // valid held high with changing fields: second accept after done
    for (int i = 0; i < 16; i++) begin
      li = 1'b1; rd = 2'(i); imm = 4'(i + 4); valid = 1'b1;
      @(negedge clk);
      if (i == 1) begin chk("b2b_c1_addr", 8'(bus0.addr), 8'd0); chk("b2b_c1_dados", 8'(bus0.dados), 8'd4); end
      if (i == 2) chk("b2b_c2_done", 8'(bus0.done), 8'd1);
      if (i == 3) begin chk("b2b_c3_ready", 8'(bus0.instr_ready), 8'd1); chk("b2b_c3_escrita", 8'(bus0.escrita), 8'd0); end
      if (i == 4) begin chk("b2b_c4_addr", 8'(bus0.addr), 8'd3); chk("b2b_c4_dados", 8'(bus0.dados), 8'd7); end
      next_cycle();
    end
    // mixed stream held valid
    for (int i = 0; i < 24; i++) begin
      li = i[0]; op = 3'(i); rd = 2'(i + 1); rs1 = 2'(i + 2); rs2 = 2'(i + 3);
      imm = 4'(15 - i); cin = i[1]; valid = 1'b1;
      next_cycle();
    end
    valid = 1'b0;
    repeat (10) next_cycle();

    // reset in the middle of EXEC
    offer(1'b0, 3'd6, 2'd2, 2'd1, 2'd3, 4'h0, 1'b1);
    next_cycle();
    next_cycle();
    reset = 1'b0;
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    chk("rst_exec_escrita", 8'(bus0.escrita), 8'd0);
    chk("rst_exec_ready", 8'(bus0.instr_ready), 8'd1);
    chk("rst_exec_done", 8'(bus0.done), 8'd0);
    chk("rst_exec_op", 8'(bus0.operacao), 8'd0);
    chk("rst_exec_ready_w2", 8'(bus1.instr_ready), 8'd1);
    next_cycle();
    @(negedge clk);
    chk("rst_exec_no_late_done", 8'(bus0.done), 8'd0);
    repeat (3) next_cycle();

    // reset during WB of the EXEC_WAIT=0 instance
    offer(1'b0, 3'd2, 2'd3, 2'd2, 2'd2, 4'h0, 1'b0);
    repeat (3) next_cycle();
    reset = 1'b0;
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    chk("rst_wb_escrita", 8'(bus0.escrita), 8'd0);
    chk("rst_wb_done", 8'(bus0.done), 8'd0);
    chk("rst_wb_ready", 8'(bus0.instr_ready), 8'd1);
    next_cycle();

    // recovery
    offer(1'b1, 3'd0, 2'd3, 2'd0, 2'd0, 4'hC, 1'b0);
    @(negedge clk);
    chk("recover_dados", 8'(bus0.dados), 8'hC);
    repeat (6) next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/datapath_ctrl.md
DATAPATH_CTRL -- requirements
Module: datapath_ctrl

Interface
REQ-001 Parameter: EXEC_WAIT, default 0, extra EXEC-state cycles inserted before writeback (legal range 0..3).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 instr_valid  input  1  instruction offered.
REQ-005 instr_ready  output  1  controller can accept an instruction; high only in IDLE.
REQ-006 instr_li  input  1  1 = load-immediate, 0 = ALU operation.
REQ-007 instr_op  input  3  ALU operation code.
REQ-008 instr_rd, instr_rs1, instr_rs2  input  2 each  destination and source register addresses.
REQ-009 instr_imm  input  4  immediate value for load-immediate.
REQ-010 instr_cin  input  1  ALU carry-in.
REQ-011 addr  output  2  register-file address.
REQ-012 escrita  output  1  register-file write enable.
REQ-013 sel21  output  1  write-data mux select: 0 = dados, 1 = ALU result.
REQ-014 sel12  output  1  read-data demux select: 0 = operand A, 1 = operand B.
REQ-015 dados  output  4  immediate data to the datapath.
REQ-016 operacao  output  3  ALU operation code; Cin  output  1  ALU carry-in.
REQ-017 done  output  1  one-cycle pulse when an instruction retires.
REQ-018 cout_in  input  1 and resultado_in  input  4  datapath feedback; used only with DPCTRL_FLAGS_EN.
REQ-019 flag_c, flag_z  output  1 each  status flags; present only with DPCTRL_FLAGS_EN.

Function
REQ-020 States: IDLE, WR_IMM, RD_A, RD_B, EXEC, WB, DONE; encoding free.
REQ-021 Accept when instr_valid && instr_ready at a rising edge; all instr_* fields latched into internal registers at that edge; later instr_* changes do not affect the operation in flight.
REQ-022 IDLE -> WR_IMM if latched li=1, else IDLE -> RD_A.
REQ-023 WR_IMM: addr=rd, sel21=0, dados=imm, escrita=1; next state DONE.
REQ-024 RD_A: addr=rs1, sel12=0, escrita=0; next RD_B.
REQ-025 RD_B: addr=rs2, sel12=1, escrita=0; next EXEC.
REQ-026 EXEC: operacao=op, Cin=cin, addr=rd, sel21=1, escrita=0; held for 1+EXEC_WAIT cycles via a down-counter; then WB.
REQ-027 WB: operacao/Cin held, addr=rd, sel21=1, escrita=1 for exactly one cycle; next DONE.
REQ-028 DONE: done=1 for one cycle, escrita=0; next IDLE.
REQ-029 operacao and Cin are held from EXEC through WB; outside those states operacao=0 and Cin=0.
REQ-030 Latency from accept edge to done high: load-immediate 2 cycles; ALU 5+EXEC_WAIT cycles.
REQ-031 Back-to-back: instr_ready returns high the cycle after DONE; minimum issue interval = latency+1 cycles.
REQ-032 instr_valid while not ready is ignored (no queuing); escrita is never high outside WR_IMM/WB.
REQ-033 rd equal to rs1 or rs2 is legal; the write occurs only in WB, after both reads.

Reset
REQ-034 reset=0 at a rising edge: state=IDLE, EXEC counter=0, all latched fields=0; regardless of the current state (including mid-WB).
REQ-035 Outputs during and after reset: instr_ready=1, addr=0, escrita=0, sel21=0, sel12=0, dados=0, operacao=0, Cin=0, done=0, flag_c=0, flag_z=0.
REQ-036 An instruction offered in the reset cycle is not accepted.

Configuration
REQ-037 Macro DPCTRL_FLAGS_EN defined: on the WB-state edge, flag_c<=cout_in and flag_z<=(resultado_in==0); flags hold until the next WB or reset; load-immediate does not change them.
REQ-038 DPCTRL_FLAGS_EN undefined: flag_c, flag_z, cout_in, resultado_in are absent from the port list; no flag logic is present.

Verification
REQ-039 Reset mid-EXEC -> next cycle IDLE, escrita=0, instr_ready=1, done=0, no WB write.
REQ-040 LI rd=2, imm=0xA -> cycle 1: addr=2, sel21=0, dados=0xA, escrita=1; cycle 2: done=1.
REQ-041 ALU op=3, rs1=0, rs2=1, rd=3, cin=1, EXEC_WAIT=0 -> addr sequence 0,1,3,3 with sel12 0,1; escrita=1 only in cycle 4; done in cycle 5.
REQ-042 EXEC_WAIT=2, ALU instr -> EXEC lasts 3 cycles; done at cycle 7.
REQ-043 instr_valid held high during busy with changing fields -> only the first instruction executes; the second is accepted the cycle after done.
REQ-044 DPCTRL_FLAGS_EN, ALU with cout_in=1, resultado_in=0 at WB -> flag_c=1, flag_z=1; following LI leaves both unchanged.
